chip8_mem_arbiter: RTL and testbench
====================================

// Module: chip8_mem_arbiter
// PURPOSE
//  Shares the single dual-byte-port Chip8_memory (4 KiB, 1-cycle synchronous read) between three requesters:
//  host/ARM bus (HOST), CPU instruction fetch (FETCH) and CPU data access (DATA: sprites, BCD, Fx55/Fx65).
//  One 1- or 2-byte access per cycle. HOST has priority, subject to an anti-starvation override.
//  FETCH/DATA alternate round-robin. CPU writes into the interpreter/font region are blocked.
// PARAMETERS
//  AW           12     byte address width (4096 B)
//  PROTECT_TOP  'h1FF  highest CPU-write-protected address (HOST writes are never blocked)
//  STARVE_MAX   8      consecutive denied cycles before a waiting CPU requester overrides HOST
// PORTS
//  clk            in   1   system clock; the block's only clock
//  reset          in   1   asynchronous, active-low (0 = reset)
//  hst_req        in   1   HOST request; held, with fields stable, until hst_gnt
//  hst_we         in   1   1 = write, 0 = read
//  hst_wide       in   1   1 = 2 bytes (addr, addr+1), 0 = 1 byte (addr)
//  hst_addr       in   AW  byte address
//  hst_wdata      in   16  [15:8] -> addr, [7:0] -> addr+1; [15:8] only when !wide
//  hst_gnt        out  1   access issued to memory this cycle
//  fch_req/fch_addr/fch_gnt  FETCH, same meaning; always a 2-byte read (no we/wide/wdata)
//  dat_req/dat_we/dat_wide/dat_addr/dat_wdata/dat_gnt  DATA, same as HOST
//  rvalid         out  1   read data valid, exactly 1 cycle after a read grant
//  rid            out  2   owner of rdata: 0 HOST, 1 FETCH, 2 DATA
//  rdata          out  16  {mem[a], mem[a+1]}; [7:0] = 0 when !wide
//  prot_err       out  1   sticky: a CPU write hit [0,PROTECT_TOP]; cleared only by reset
//  mem_addr1/mem_addr2   out AW  to memory addr1/addr2
//  mem_wd1/mem_wd2       out 8   to memory writedata1/2
//  mem_we1/mem_we2       out 1   to memory WE1/WE2
//  mem_rd1/mem_rd2       in  8   from memory readdata1/2
// BEHAVIOUR
//  - Reset (async assert, sync deassert): all gnt, rvalid, mem_we*, prot_err = 0; rid = 0; rdata = 0;
//    RR pointer = FETCH; starve counters = 0. A read granted in the reset cycle never produces rvalid.
//  - Grant (combinational from req, at most one gnt per cycle):
//    1) if fch or dat starve count == STARVE_MAX and it is requesting, that one (both: RR order);
//    2) else HOST if hst_req; 3) else FETCH/DATA by round-robin.
//    RR pointer moves to the non-granted CPU requester after any CPU grant.
//  - Starve counter per CPU requester: +1 each cycle req && !gnt, saturating at STARVE_MAX; 0 on gnt or !req.
//  - Issue cycle: mem_addr1 = addr; mem_addr2 = addr+1 mod 2^AW (0xFFF -> 0x000).
//    Write: mem_we1 = 1; mem_we2 = wide. Outputs are combinational, valid in the gnt cycle.
//  - Protection: CPU (DATA) write whose addr, or addr+1 when wide, lies in [0,PROTECT_TOP]:
//    gnt still returned (requester completes), both mem_we forced 0, prot_err set next edge.
//  - Read return: registered rvalid/rid in cycle after gnt; rdata driven from mem_rd1/mem_rd2 in that
//    cycle. rvalid never asserts for writes. Back-to-back reads give rvalid every cycle.
//  - When no requester is active: mem_we* = 0, addresses hold last value (don't-care).
//  - Requester dropping req before gnt: legal, request vanishes, starve counter clears.
// STRUCTURE
//  - chip8_pkg: typedef enum logic [1:0] {REQ_HOST, REQ_FETCH, REQ_DATA} req_id_t;
//    localparams CHIP8_AW = 12, CHIP8_PROG_START = 'h200.
//  - Sub-module chip8_rr_arb2: 2-way round-robin with pointer + starve counters.
//    Top applies HOST priority/override and muxes the memory port.
// TESTING
//  1 Reset low mid-read (gnt at t, reset at t+0.5) -> no rvalid at t+1; prot_err=0, all gnt=0.
//  2 hst write wide 0x300=0xABCD, then fch read 0x300 -> mem_we1/2=1; rvalid next cycle,
//    rid=1, rdata=0xABCD.
//  3 fch_req and dat_req held 4 cycles, no HOST -> grants alternate F,D,F,D (pointer starts FETCH).
//  4 hst_req held continuously, fch_req held -> fch_gnt on 9th cycle (STARVE_MAX=8); HOST resumes after.
//  5 dat write wide at 0x1FF -> dat_gnt=1, mem_we1=mem_we2=0, prot_err=1 until reset;
//    same from HOST -> writes.
//  6 fch read 0xFFF -> mem_addr2=0x000, rdata={mem[0xFFF],mem[0x000]}; narrow DATA read -> rdata[7:0]=0.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 memory subsystem.
// Requester ids double as the rid tag returned with read data.
package chip8_pkg;

  typedef enum logic [1:0] {
    REQ_HOST  = 2'd0,
    REQ_FETCH = 2'd1,
    REQ_DATA  = 2'd2
  } req_id_t;

  localparam int CHIP8_AW         = 12;
  localparam int CHIP8_PROG_START = 'h200;

endpackage

// File: rtl/chip8_rr_arb2.sv
// Two-way FETCH/DATA round-robin arbiter with per-requester starvation counters.
// A starved requester wins even against HOST; otherwise HOST blocks both CPU requesters.
module chip8_rr_arb2 #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_hst_req,
  input  logic i_fch_req,
  input  logic i_dat_req,
  output logic o_fch_gnt,
  output logic o_dat_gnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_fch_cnt;
  logic [CW-1:0] r_dat_cnt;
  logic          r_ptr_dat;   // 0: FETCH preferred on a tie, 1: DATA preferred
  logic          w_fch_starve;
  logic          w_dat_starve;
  logic          w_fch_cand;
  logic          w_dat_cand;

  assign w_fch_starve = i_fch_req && (r_fch_cnt == LP_MAX);
  assign w_dat_starve = i_dat_req && (r_dat_cnt == LP_MAX);

  // Candidates: starved requesters override HOST; otherwise CPU only competes when HOST is idle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_fch_cand = 1'b0;
    w_dat_cand = 1'b0;
    if (w_fch_starve || w_dat_starve) begin
      w_fch_cand = w_fch_starve;
      w_dat_cand = w_dat_starve;
    end else if (!i_hst_req) begin
      w_fch_cand = i_fch_req;
      w_dat_cand = i_dat_req;
    end
  end

  always_comb begin
    o_fch_gnt = 1'b0;
    o_dat_gnt = 1'b0;
    if (i_en) begin
      if (w_fch_cand && w_dat_cand) begin
        o_fch_gnt = !r_ptr_dat;
        o_dat_gnt = r_ptr_dat;
      end else begin
        o_fch_gnt = w_fch_cand;
        o_dat_gnt = w_dat_cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr_dat <= 1'b0;
      r_fch_cnt <= '0;
      r_dat_cnt <= '0;
    end else begin
      if (o_fch_gnt)      r_ptr_dat <= 1'b1;
      else if (o_dat_gnt) r_ptr_dat <= 1'b0;

      if (i_fch_req && !o_fch_gnt)
        r_fch_cnt <= (r_fch_cnt == LP_MAX) ? r_fch_cnt : r_fch_cnt + CW'(1);
      else
        r_fch_cnt <= '0;

      if (i_dat_req && !o_dat_gnt)
        r_dat_cnt <= (r_dat_cnt == LP_MAX) ? r_dat_cnt : r_dat_cnt + CW'(1);
      else
        r_dat_cnt <= '0;
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Shares the dual-byte-port CHIP-8 memory between HOST, FETCH and DATA requesters.
// HOST has priority unless a CPU requester has starved; CPU writes below PROTECT_TOP+1 are dropped.
module chip8_mem_arbiter
  import chip8_pkg::*;
#(
  parameter int AW          = CHIP8_AW,
  parameter int PROTECT_TOP = CHIP8_PROG_START - 1,
  parameter int STARVE_MAX  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hst_req,
  input  logic          hst_we,
  input  logic          hst_wide,
  input  logic [AW-1:0] hst_addr,
  input  logic [15:0]   hst_wdata,
  output logic          hst_gnt,
  input  logic          fch_req,
  input  logic [AW-1:0] fch_addr,
  output logic          fch_gnt,
  input  logic          dat_req,
  input  logic          dat_we,
  input  logic          dat_wide,
  input  logic [AW-1:0] dat_addr,
  input  logic [15:0]   dat_wdata,
  output logic          dat_gnt,
  output logic          rvalid,
  output logic [1:0]    rid,
  output logic [15:0]   rdata,
  output logic          prot_err,
  output logic [AW-1:0] mem_addr1,
  output logic [AW-1:0] mem_addr2,
  output logic [7:0]    mem_wd1,
  output logic [7:0]    mem_wd2,
  output logic          mem_we1,
  output logic          mem_we2,
  input  logic [7:0]    mem_rd1,
  input  logic [7:0]    mem_rd2
);

  localparam logic [AW-1:0] LP_PROT_TOP = AW'(PROTECT_TOP);

  logic          w_fch_gnt;
  logic          w_dat_gnt;
  logic          w_hst_gnt;
  logic          w_any_gnt;
  req_id_t       w_sel_id;
  logic          w_we;
  logic          w_wide;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_addr2;
  logic [15:0]   w_wdata;
  logic          w_prot_hit;

  logic [AW-1:0] r_last_addr;
  logic          r_rvalid;
  req_id_t       r_rid;
  logic          r_wide;
  logic          r_prot_err;

  chip8_rr_arb2 #(.STARVE_MAX(STARVE_MAX)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_en      (reset),
    .i_hst_req (hst_req),
    .i_fch_req (fch_req),
    .i_dat_req (dat_req),
    .o_fch_gnt (w_fch_gnt),
    .o_dat_gnt (w_dat_gnt)
  );

  assign w_hst_gnt = reset && hst_req && !w_fch_gnt && !w_dat_gnt;
  assign w_any_gnt = w_hst_gnt || w_fch_gnt || w_dat_gnt;

  always_comb begin
    w_sel_id = REQ_HOST;
    w_we     = 1'b0;
    w_wide   = 1'b0;
    w_addr   = r_last_addr;
    w_wdata  = 16'h0000;
    if (w_hst_gnt) begin
      w_sel_id = REQ_HOST;
      w_we     = hst_we;
      w_wide   = hst_wide;
      w_addr   = hst_addr;
      w_wdata  = hst_wdata;
    end else if (w_fch_gnt) begin
      w_sel_id = REQ_FETCH;
      w_wide   = 1'b1;
      w_addr   = fch_addr;
    end else if (w_dat_gnt) begin
      w_sel_id = REQ_DATA;
      w_we     = dat_we;
      w_wide   = dat_wide;
      w_addr   = dat_addr;
      w_wdata  = dat_wdata;
    end
  end

  // Second byte wraps naturally at the top of the address space.
  assign w_addr2    = w_addr + AW'(1);
  assign w_prot_hit = w_dat_gnt && dat_we &&
                      ((w_addr <= LP_PROT_TOP) || (dat_wide && (w_addr2 <= LP_PROT_TOP)));

  assign mem_addr1 = w_addr;
  assign mem_addr2 = w_addr2;
  assign mem_wd1   = w_wdata[15:8];
  assign mem_wd2   = w_wdata[7:0];
  assign mem_we1   = w_any_gnt && w_we && !w_prot_hit;
  assign mem_we2   = mem_we1 && w_wide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_addr <= '0;
      r_rvalid    <= 1'b0;
      r_rid       <= REQ_HOST;
      r_wide      <= 1'b0;
      r_prot_err  <= 1'b0;
    end else begin
      r_rvalid   <= w_any_gnt && !w_we;
      r_prot_err <= r_prot_err || w_prot_hit;
      if (w_any_gnt) r_last_addr <= w_addr;
      if (w_any_gnt && !w_we) begin
        r_rid  <= w_sel_id;
        r_wide <= w_wide;
      end
    end
  end

  assign hst_gnt  = w_hst_gnt;
  assign fch_gnt  = w_fch_gnt;
  assign dat_gnt  = w_dat_gnt;
  assign rvalid   = r_rvalid;
  assign rid      = r_rid;
  assign prot_err = r_prot_err;
  assign rdata    = r_rvalid ? {mem_rd1, (r_wide ? mem_rd2 : 8'h00)} : 16'h0000;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Scoreboard bench for chip8_mem_arbiter with a behavioural 4 KiB sync-read memory.
// Read expectations come from a shadow copy of memory and are checked the cycle after issue.
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hst_req, hst_we, hst_wide;
  logic [11:0] hst_addr;
  logic [15:0] hst_wdata;
  logic        hst_gnt;
  logic        fch_req;
  logic [11:0] fch_addr;
  logic        fch_gnt;
  logic        dat_req, dat_we, dat_wide;
  logic [11:0] dat_addr;
  logic [15:0] dat_wdata;
  logic        dat_gnt;
  logic        rvalid;
  logic [1:0]  rid;
  logic [15:0] rdata;
  logic        prot_err;
  logic [11:0] mem_addr1, mem_addr2;
  logic [7:0]  mem_wd1, mem_wd2;
  logic        mem_we1, mem_we2;
  logic [7:0]  mem_rd1, mem_rd2;

  chip8_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .hst_req(hst_req), .hst_we(hst_we), .hst_wide(hst_wide), .hst_addr(hst_addr),
    .hst_wdata(hst_wdata), .hst_gnt(hst_gnt),
    .fch_req(fch_req), .fch_addr(fch_addr), .fch_gnt(fch_gnt),
    .dat_req(dat_req), .dat_we(dat_we), .dat_wide(dat_wide), .dat_addr(dat_addr),
    .dat_wdata(dat_wdata), .dat_gnt(dat_gnt),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .prot_err(prot_err),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_wd1(mem_wd1), .mem_wd2(mem_wd2),
    .mem_we1(mem_we1), .mem_we2(mem_we2), .mem_rd1(mem_rd1), .mem_rd2(mem_rd2)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  logic [7:0] sh  [0:4095];

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 4) ^ 8'h5A);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = init_byte(i);
      sh[i]  = init_byte(i);
    end
  end

  always @(posedge clk) begin
    if (mem_we1) mem[mem_addr1] <= mem_wd1;
    if (mem_we2) mem[mem_addr2] <= mem_wd2;
    mem_rd1 <= mem[mem_addr1];
    mem_rd2 <= mem[mem_addr2];
  end

  typedef struct {
    logic [1:0]  rid;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_prot = 1'b0;

  task automatic clear_inputs();
    hst_req = 0; hst_we = 0; hst_wide = 0; hst_addr = '0; hst_wdata = '0;
    fch_req = 0; fch_addr = '0;
    dat_req = 0; dat_we = 0; dat_wide = 0; dat_addr = '0; dat_wdata = '0;
  endtask

  task automatic check_return(input string tag);
    exp_t e;
    total++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (rvalid !== 1'b1 || rid !== e.rid || rdata !== e.data) begin
        bad++;
        $display("FAIL %s return: got rvalid=%b rid=%0d rdata=%h, want rvalid=1 rid=%0d rdata=%h",
                 tag, rvalid, rid, rdata, e.rid, e.data);
      end
    end else if (rvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s spurious rvalid: got %b want 0", tag, rvalid);
    end
  endtask

  // Inputs are already driven (posedge+1); checks happen at the following negedge.
  task automatic run_cycle(input logic eh, input logic ef, input logic ed, input string tag);
    logic [11:0] a, a2;
    logic        we, wide, prot;
    logic [15:0] wd;
    logic [1:0]  id;
    @(negedge clk);
    check_return(tag);
    total++;
    if ({hst_gnt, fch_gnt, dat_gnt} !== {eh, ef, ed}) begin
      bad++;
      $display("FAIL %s gnt h/f/d: got %b%b%b want %b%b%b", tag, hst_gnt, fch_gnt, dat_gnt, eh, ef, ed);
    end
    total++;
    if (prot_err !== exp_prot) begin
      bad++;
      $display("FAIL %s prot_err: got %b want %b", tag, prot_err, exp_prot);
    end
    if (eh || ef || ed) begin
      if (eh) begin
        a = hst_addr; we = hst_we; wide = hst_wide; wd = hst_wdata; id = 2'd0;
      end else if (ef) begin
        a = fch_addr; we = 1'b0; wide = 1'b1; wd = 16'h0; id = 2'd1;
      end else begin
        a = dat_addr; we = dat_we; wide = dat_wide; wd = dat_wdata; id = 2'd2;
      end
      a2   = a + 12'd1;
      prot = ed && we && ((a <= 12'h1FF) || (wide && (a2 <= 12'h1FF)));
      total++;
      if (mem_addr1 !== a || mem_addr2 !== a2 || mem_we1 !== (we && !prot) ||
          mem_we2 !== (we && wide && !prot)) begin
        bad++;
        $display("FAIL %s port: got a1=%h a2=%h we=%b%b want a1=%h a2=%h we=%b%b", tag,
                 mem_addr1, mem_addr2, mem_we1, mem_we2, a, a2, we && !prot, we && wide && !prot);
      end
      if (we && !prot) begin
        total++;
        if (mem_wd1 !== wd[15:8] || (wide && mem_wd2 !== wd[7:0])) begin
          bad++;
          $display("FAIL %s wdata: got %h%h want %h", tag, mem_wd1, mem_wd2, wd);
        end
        sh[a] = wd[15:8];
        if (wide) sh[a2] = wd[7:0];
      end
      if (!we) sb.push_back('{id, {sh[a], (wide ? sh[a2] : 8'h00)}});
      if (prot) exp_prot = 1'b1;
    end else begin
      total++;
      if (mem_we1 !== 1'b0 || mem_we2 !== 1'b0) begin
        bad++;
        $display("FAIL %s idle we: got %b%b want 00", tag, mem_we1, mem_we2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    fch_req = 1'b1;
    hst_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({hst_gnt, fch_gnt, dat_gnt, rvalid, prot_err, mem_we1, mem_we2} !== 7'b0 ||
        rid !== 2'd0 || rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset state: gnt=%b%b%b rvalid=%b prot=%b we=%b%b rid=%0d rdata=%h, want all 0",
               hst_gnt, fch_gnt, dat_gnt, rvalid, prot_err, mem_we1, mem_we2, rid, rdata);
    end
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    fch_req  = 1'b1;
    fch_addr = 12'h050;
    @(negedge clk);
    total++;
    if (fch_gnt !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_read gnt: got %b want 1", fch_gnt);
    end
    reset   = 1'b0;
    fch_req = 1'b0;
    @(negedge clk);
    total++;
    if (rvalid !== 1'b0 || prot_err !== 1'b0 || {hst_gnt, fch_gnt, dat_gnt} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_read: got rvalid=%b prot=%b gnt=%b%b%b want 0 0 000",
               rvalid, prot_err, hst_gnt, fch_gnt, dat_gnt);
    end
    reset = 1'b1;
    exp_prot = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    fch_req = 1'b1; fch_addr = 12'h010;
    dat_req = 1'b1; dat_we = 1'b0; dat_wide = 1'b0; dat_addr = 12'h020;
    run_cycle(0, 1, 0, "rr1");
    run_cycle(0, 0, 1, "rr2");
    run_cycle(0, 1, 0, "rr3");
    run_cycle(0, 0, 1, "rr4");
    clear_inputs();
    run_cycle(0, 0, 0, "rr_drain");
  endtask

  task automatic test_host_write_fetch();
    hst_req = 1'b1; hst_we = 1'b1; hst_wide = 1'b1; hst_addr = 12'h300; hst_wdata = 16'hABCD;
    run_cycle(1, 0, 0, "hwr");
    clear_inputs();
    fch_req = 1'b1; fch_addr = 12'h300;
    run_cycle(0, 1, 0, "frd");
    clear_inputs();
    run_cycle(0, 0, 0, "frd_ret");
  endtask

  task automatic test_starve();
    hst_req = 1'b1; hst_we = 1'b0; hst_wide = 1'b1; hst_addr = 12'h040;
    fch_req = 1'b1; fch_addr = 12'h060;
    for (int i = 1; i <= 8; i++) run_cycle(1, 0, 0, $sformatf("starve_h%0d", i));
    run_cycle(0, 1, 0, "starve_f9");
    run_cycle(1, 0, 0, "starve_h10");
    fch_req = 1'b0;
    run_cycle(1, 0, 0, "starve_h11");
    clear_inputs();
    run_cycle(0, 0, 0, "starve_drain");
  endtask

  task automatic test_protect();
    dat_req = 1'b1; dat_we = 1'b1; dat_wide = 1'b1; dat_addr = 12'h1FF; dat_wdata = 16'h1234;
    run_cycle(0, 0, 1, "prot_dwr");
    clear_inputs();
    hst_req = 1'b1; hst_we = 1'b1; hst_wide = 1'b1; hst_addr = 12'h1FF; hst_wdata = 16'h5678;
    run_cycle(1, 0, 0, "prot_hwr");
    clear_inputs();
    dat_req = 1'b1; dat_we = 1'b0; dat_wide = 1'b1; dat_addr = 12'h1FF;
    run_cycle(0, 0, 1, "prot_drd");
    dat_we = 1'b1; dat_wide = 1'b0; dat_addr = 12'h200; dat_wdata = 16'h99EE;
    run_cycle(0, 0, 1, "prot_ok_wr");
    dat_we = 1'b1; dat_wide = 1'b1; dat_addr = 12'h1FE; dat_wdata = 16'hDEAD;
    run_cycle(0, 0, 1, "prot_dwr2");
    dat_we = 1'b0; dat_wide = 1'b1; dat_addr = 12'h1FE;
    run_cycle(0, 0, 1, "prot_drd2");
    dat_addr = 12'h1FF;
    run_cycle(0, 0, 1, "prot_drd3");
    clear_inputs();
    run_cycle(0, 0, 0, "prot_drain");
  endtask

  task automatic test_wrap_narrow();
    fch_req = 1'b1; fch_addr = 12'hFFF;
    run_cycle(0, 1, 0, "wrap_frd");
    clear_inputs();
    dat_req = 1'b1; dat_we = 1'b0; dat_wide = 1'b0; dat_addr = 12'h123;
    run_cycle(0, 0, 1, "narrow_drd");
    clear_inputs();
    run_cycle(0, 0, 0, "narrow_drain");
  endtask

  task automatic test_prot_reset();
    reset = 1'b0;
    #2;
    total++;
    if (prot_err !== 1'b0) begin
      bad++;
      $display("FAIL prot_reset: got %b want 0", prot_err);
    end
    exp_prot = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_host_write_fetch();
    test_starve();
    test_protect();
    test_wrap_narrow();
    test_prot_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
